cla_response_checker: RTL

- Synthesizable response checker for the 4-bit carry-lookahead adder; it is the consuming end of the adder's exhaustive stimulus sweep.
- Accepts one observed vector per cycle: operands, carry-in, and the adder's S/Cout/Po/Go.
- Recomputes the golden result in a 2-stage pipeline, counts vectors and mismatches, and latches the first failing vector.
- Sits beside the adder in bring-up and on-FPGA self-test, so the sweep reports pass/fail without a waveform viewer.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_golden_model.sv | 38 +++
 rtl/cla_response_checker.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder checkers.
//   CLA_WIDTH    default operand width
//   cla_state_e  response-checker FSM encoding
//   cla_obs_t    observed adder outputs {go,po,cout,s} at the default width
package cla_pkg;

   localparam int CLA_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } cla_state_e;

   typedef struct packed {
      logic                 go;
      logic                 po;
      logic                 cout;
      logic [CLA_WIDTH-1:0] s;
   } cla_obs_t;

endpackage

// File: rtl/cla_golden_model.sv
// Golden reference for a WIDTH-bit carry-lookahead adder. Purely combinational.
// Ports:
//   i_a, i_b      operands
//   i_cin         carry-in
//   o_exp_s       expected sum (low WIDTH bits of a+b+cin)
//   o_exp_cout    expected carry-out
//   o_exp_po      expected group propagate, &(a^b)
//   o_exp_go      expected group generate, carry-out of a+b with cin forced 0
module cla_golden_model #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_exp_s,
   output logic             o_exp_cout,
   output logic             o_exp_po,
   output logic             o_exp_go
);

   logic [WIDTH:0] w_sum;
   logic           w_carry;

   assign w_sum      = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
   assign o_exp_s    = w_sum[WIDTH-1:0];
   assign o_exp_cout = w_sum[WIDTH];
   assign o_exp_po   = &(i_a ^ i_b);

   // Group generate is the ripple of per-bit g/p starting from a zero carry.
   always_comb begin
      w_carry = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         w_carry = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & w_carry);
      end
      o_exp_go = w_carry;
   end

endmodule

// File: rtl/cla_response_checker.sv
// Response checker for the carry-lookahead adder sweep. Accepts one observed
// vector per cycle, recomputes the golden result through a 2-stage pipeline,
// counts vectors and mismatches and latches the first failing vector.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start, num_vectors     run request (IDLE/DONE only) and run length
//   in_valid, in_ready     observation handshake
//   a, b, cin              stimulus applied to the adder
//   s, cout, po, go        adder response
//   busy, done, pass       run status; pass meaningful only while done
//   vec_count, err_count   compared vectors, saturating mismatch count
//   fail_valid, fail_vec, fail_obs   first failure {cin,b,a} and {go,po,cout,s}
//
// state    | meaning
// ST_IDLE  | waiting for start, no vectors accepted
// ST_RUN   | accepting vectors until the target count is reached
// ST_DRAIN | target reached, letting the pipeline empty
// ST_DONE  | results final; start begins another run
module cla_response_checker
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int CNT_W = 20,
   parameter int ERR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   num_vectors,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cin,
   input  logic [WIDTH-1:0]   s,
   input  logic               cout,
   input  logic               po,
   input  logic               go,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   vec_count,
   output logic [ERR_W-1:0]   err_count,
   output logic               fail_valid,
   output logic [2*WIDTH:0]   fail_vec,
   output logic [WIDTH+2:0]   fail_obs
);

   typedef struct packed {
      logic             go;
      logic             po;
      logic             cout;
      logic [WIDTH-1:0] s;
   } obs_t;

   cla_state_e       r_state;
   cla_state_e       w_state_nxt;

   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] r_acc_cnt;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s1_cin;
   obs_t             r_s1_obs;

   logic             r_s2_valid;
   logic             r_s2_mismatch;
   logic [2*WIDTH:0] r_s2_vec;
   obs_t             r_s2_obs;

   logic [CNT_W-1:0] r_vec_count;
   logic [ERR_W-1:0] r_err_count;
   logic             r_fail_valid;
   logic [2*WIDTH:0] r_fail_vec;
   obs_t             r_fail_obs;

   logic [WIDTH-1:0] w_exp_s;
   logic             w_exp_cout;
   logic             w_exp_po;
   logic             w_exp_go;
   logic             w_mismatch;

   logic             w_start_ok;
   logic             w_xfer;
   logic             w_target_hit;
   logic             w_last_xfer;
   logic             w_pipe_empty;

   assign w_start_ok   = start && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_xfer       = in_valid && in_ready;
   assign w_target_hit = (r_acc_cnt == r_target);
   assign w_last_xfer  = w_xfer && ((r_acc_cnt + CNT_W'(1)) == r_target);
   assign w_pipe_empty = !r_s1_valid && !r_s2_valid;

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_last_xfer) begin
               w_state_nxt = ST_DRAIN;
            end else if (w_target_hit) begin
               // Only a zero-length run gets here; nothing is in flight.
               w_state_nxt = w_pipe_empty ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_pipe_empty) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      pass     = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            in_ready = !w_target_hit;
            busy     = 1'b1;
         end
         ST_DRAIN: begin
            busy = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
            pass = (r_err_count == '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_target  <= '0;
         r_acc_cnt <= '0;
      end else if (w_start_ok) begin
         r_target  <= num_vectors;
         r_acc_cnt <= '0;
      end else if (w_xfer) begin
         r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      end
   end

   // Stage 1: capture the accepted observation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_cin   <= 1'b0;
         r_s1_obs   <= '0;
      end else begin
         r_s1_valid <= w_xfer;
         if (w_xfer) begin
            r_s1_a   <= a;
            r_s1_b   <= b;
            r_s1_cin <= cin;
            r_s1_obs <= '{go: go, po: po, cout: cout, s: s};
         end
      end
   end

   cla_golden_model #(
      .WIDTH (WIDTH)
   ) u_golden (
      .i_a        (r_s1_a),
      .i_b        (r_s1_b),
      .i_cin      (r_s1_cin),
      .o_exp_s    (w_exp_s),
      .o_exp_cout (w_exp_cout),
      .o_exp_po   (w_exp_po),
      .o_exp_go   (w_exp_go)
   );

   assign w_mismatch = (r_s1_obs.s    != w_exp_s)    ||
                       (r_s1_obs.cout != w_exp_cout) ||
                       (r_s1_obs.po   != w_exp_po)   ||
                       (r_s1_obs.go   != w_exp_go);

   // Stage 2: register the compare result with the vector it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid    <= 1'b0;
         r_s2_mismatch <= 1'b0;
         r_s2_vec      <= '0;
         r_s2_obs      <= '0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_mismatch <= w_mismatch;
            r_s2_vec      <= {r_s1_cin, r_s1_b, r_s1_a};
            r_s2_obs      <= r_s1_obs;
         end
      end
   end

   // Result counters and first-failure capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec_count  <= '0;
         r_err_count  <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
         r_fail_obs   <= '0;
      end else if (w_start_ok) begin
         r_vec_count  <= '0;
         r_err_count  <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
         r_fail_obs   <= '0;
      end else if (r_s2_valid) begin
         r_vec_count <= r_vec_count + CNT_W'(1);
         if (r_s2_mismatch) begin
            if (r_err_count != '1) r_err_count <= r_err_count + ERR_W'(1);
            if (!r_fail_valid) begin
               r_fail_valid <= 1'b1;
               r_fail_vec   <= r_s2_vec;
               r_fail_obs   <= r_s2_obs;
            end
         end
      end
   end

   assign vec_count  = r_vec_count;
   assign err_count  = r_err_count;
   assign fail_valid = r_fail_valid;
   assign fail_vec   = r_fail_vec;
   assign fail_obs   = r_fail_obs;

endmodule
